// File: rtl/pll_lock_supervisor.sv
// Bring-up sequencer for one iCE40 PLL: PLL reset pulse, lock wait with timeout,
// lock stability window, bounded retries, and downstream reset release.
module pll_lock_supervisor #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 120000,
    parameter int unsigned SETTLE_CYCLES = 1200,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked_in,
    output logic       pll_reset_out,
    output logic       reset_out,
    output logic       ready_out,
    output logic       fault_out,
    output logic [3:0] retry_count,
    output logic [3:0] loss_count
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    localparam logic [23:0] RESET_LAST   = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] SETTLE_LAST  = 24'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  sync_q;
    logic [3:0]  retry_q, retry_d;
    logic [3:0]  loss_q, loss_d;
    logic        pll_rst_q, pll_rst_d;
    logic        rst_out_q, rst_out_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        locked_s;

    assign locked_s = sync_q[1];

    // NOTE: every state element uses <= so all registers update together at the edge.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            sync_q    <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[0], locked_in};
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 4'd1;
                    cnt_d   = '0;
                    state_d = (retry_d == RETRY_LIMIT) ? FAULT : PLL_RST;
                end
            end
            SETTLE: begin
                // Any dropout restarts the lock wait without charging a retry.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = PLL_RST;
                    if (loss_q != 4'hF) begin
                        loss_d = loss_q + 4'd1;
                    end
                end
            end
            FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register on the transition edge.
        pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
        rst_out_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    assign pll_reset_out = pll_rst_q;
    assign reset_out     = rst_out_q;
    assign ready_out     = ready_q;
    assign fault_out     = fault_q;
    assign retry_count   = retry_q;
    assign loss_count    = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pll_lock_supervisor;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       locked_in = 1'b0;
    logic       pll_reset_out, reset_out, ready_out, fault_out;
    logic [3:0] retry_count, loss_count;
    logic [11:0] obs;

    pll_lock_supervisor #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (16),
        .SETTLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .locked_in    (locked_in),
        .pll_reset_out(pll_reset_out),
        .reset_out    (reset_out),
        .ready_out    (ready_out),
        .fault_out    (fault_out),
        .retry_count  (retry_count),
        .loss_count   (loss_count)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    assign obs = {pll_reset_out, reset_out, ready_out, fault_out, retry_count, loss_count};

    typedef struct {
        int          cyc;
        logic [11:0] outs;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic void expect_out(int c, bit pr, bit rs, bit rd, bit ft, int rc, int lc, string nm);
        exp_t e;
        e.cyc  = c;
        e.outs = {pr, rs, rd, ft, 4'(rc), 4'(lc)};
        e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic void exp_rst(int c, int rc, int lc, string nm);
        expect_out(c, 1'b1, 1'b1, 1'b0, 1'b0, rc, lc, nm);
    endfunction

    function automatic void exp_wait(int c, int rc, int lc, string nm);
        expect_out(c, 1'b0, 1'b1, 1'b0, 1'b0, rc, lc, nm);
    endfunction

    function automatic void exp_run(int c, int lc, string nm);
        expect_out(c, 1'b0, 1'b0, 1'b1, 1'b0, 0, lc, nm);
    endfunction

    function automatic void exp_fault(int c, int rc, int lc, string nm);
        expect_out(c, 1'b1, 1'b1, 1'b0, 1'b1, rc, lc, nm);
    endfunction

    // Monitor: compares mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock_in);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc < cyc) begin
                    $display("FAIL %s: expectation for cycle %0d was never sampled (now cycle %0d)",
                             e.name, e.cyc, cyc);
                end else if (obs !== e.outs) begin
                    $display("FAIL %s @cycle %0d: got pr=%b rs=%b rd=%b ft=%b rc=%0d lc=%0d, want pr=%b rs=%b rd=%b ft=%b rc=%0d lc=%0d",
                             e.name, cyc, obs[11], obs[10], obs[9], obs[8], obs[7:4], obs[3:0],
                             e.outs[11], e.outs[10], e.outs[9], e.outs[8], e.outs[7:4], e.outs[3:0]);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic at_cycle(int c);
        while (cyc < c) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic apply_reset(output int b);
        reset = 1'b1;
        repeat (3) @(posedge clock_in);
        #1;
        reset = 1'b0;
        b = cyc;
    endtask

    initial begin
        int b;
        int d;
        int lc_prev;
        int lc_new;

        apply_reset(b);

        // 1. Normal bring-up: lock at cycle 10, ready at cycle 21.
        for (int i = 0; i < 25; i++) begin
            if (i < 4)       exp_rst(b + i, 0, 0, "t1_pll_rst");
            else if (i < 21) exp_wait(b + i, 0, 0, "t1_wait_settle");
            else             exp_run(b + i, 0, "t1_run");
        end
        at_cycle(b + 10); locked_in = 1'b1;
        at_cycle(b + 25); locked_in = 1'b0;
        apply_reset(b);

        // 2. Lock high 5, low 1, then high: ready 11 cycles after the final rise.
        for (int i = 0; i < 25; i++) begin
            if (i < 4)       exp_rst(b + i, 0, 0, "t2_pll_rst");
            else if (i < 23) exp_wait(b + i, 0, 0, "t2_no_early_ready");
            else             exp_run(b + i, 0, "t2_run");
        end
        at_cycle(b + 6);  locked_in = 1'b1;
        at_cycle(b + 11); locked_in = 1'b0;
        at_cycle(b + 12); locked_in = 1'b1;
        at_cycle(b + 25); locked_in = 1'b0;
        apply_reset(b);

        // 3. One timeout, retry pulse, then lock clears retry_count.
        for (int i = 0; i < 41; i++) begin
            if (i < 4)       exp_rst(b + i, 0, 0, "t3_pll_rst");
            else if (i < 20) exp_wait(b + i, 0, 0, "t3_wait_first");
            else if (i < 24) exp_rst(b + i, 1, 0, "t3_retry_pulse");
            else if (i < 37) exp_wait(b + i, 1, 0, "t3_wait_second");
            else             exp_run(b + i, 0, "t3_run_retry_cleared");
        end
        at_cycle(b + 26); locked_in = 1'b1;
        at_cycle(b + 41); locked_in = 1'b0;
        apply_reset(b);

        // 4. Two timeouts latch FAULT; locked_in ignored; reset clears it asynchronously.
        for (int i = 0; i < 61; i++) begin
            if (i < 4)       exp_rst(b + i, 0, 0, "t4_pll_rst");
            else if (i < 20) exp_wait(b + i, 0, 0, "t4_wait_first");
            else if (i < 24) exp_rst(b + i, 1, 0, "t4_retry_pulse");
            else if (i < 40) exp_wait(b + i, 1, 0, "t4_wait_second");
            else             exp_fault(b + i, 2, 0, "t4_fault_held");
        end
        at_cycle(b + 45); locked_in = 1'b1;
        at_cycle(b + 50); locked_in = 1'b0;
        at_cycle(b + 52); locked_in = 1'b1;
        at_cycle(b + 55); locked_in = 1'b0;
        at_cycle(b + 61);
        exp_rst(b + 61, 0, 0, "t4_reset_clears_fault");
        #1;
        apply_reset(b);

        // 5. Lock loss in RUN, repeated 17 times; loss_count saturates at 15.
        for (int i = 0; i < 4; i++) exp_rst(b + i, 0, 0, "t5_pll_rst");
        exp_wait(b + 4, 0, 0, "t5_wait");
        exp_wait(b + 16, 0, 0, "t5_settle_last");
        exp_run(b + 17, 0, "t5_first_run");
        at_cycle(b + 6); locked_in = 1'b1;
        d = b + 20;
        for (int k = 0; k < 17; k++) begin
            lc_prev = (k < 15) ? k : 15;
            lc_new  = (k + 1 < 15) ? k + 1 : 15;
            exp_run(d, lc_prev, "t5_run_before_loss");
            exp_run(d + 2, lc_prev, "t5_run_sync_delay");
            exp_rst(d + 3, 0, lc_new, "t5_loss_reset");
            exp_rst(d + 6, 0, lc_new, "t5_reset_pulse_end");
            exp_wait(d + 7, 0, lc_new, "t5_reacquire_wait");
            exp_wait(d + 18, 0, lc_new, "t5_settle_last");
            exp_run(d + 19, lc_new, "t5_reacquired");
            at_cycle(d);     locked_in = 1'b0;
            at_cycle(d + 8); locked_in = 1'b1;
            d += 22;
        end

        // 6. Asynchronous reset mid-SETTLE, then restart from PLL_RST with lock already high.
        exp_run(d, 15, "t6_run");
        exp_rst(d + 3, 0, 15, "t6_loss_reset");
        exp_wait(d + 13, 0, 15, "t6_in_settle");
        at_cycle(d);     locked_in = 1'b0;
        at_cycle(d + 8); locked_in = 1'b1;
        at_cycle(d + 14);
        exp_rst(d + 14, 0, 0, "t6_async_reset");
        #1;
        apply_reset(b);
        for (int i = 0; i < 4; i++) exp_rst(b + i, 0, 0, "t6_restart_pll_rst");
        exp_wait(b + 4, 0, 0, "t6_restart_wait");
        exp_wait(b + 12, 0, 0, "t6_restart_settle_last");
        exp_run(b + 13, 0, "t6_restart_run");
        at_cycle(b + 16);

        while (sb.size() > 0) begin
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
